gigatron_ps2_input: RTL

// - Input-side counterpart of the Gigatron OUT/VGA path: drives the CPU's 8-bit inreg from a PS/2 keyboard.
// - Receives PS/2 frames, decodes scan-code set 2, and presents either an ASCII byte or active-low gamepad bits.
// - Ties ASCII hold time to Gigatron frames, counted on vsync (out[7]), so the ROM samples each key exactly as a pad.

---
 rtl/gigatron_ps2_input_pkg.sv | 28 ++
 rtl/gigatron_ps2_keymap.sv | 67 ++++++
 rtl/gigatron_ps2_input.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/gigatron_ps2_input_pkg.sv
// Shared constants and types for the Gigatron PS/2 input block: scan codes,
// gamepad bit positions and the frame receiver state encoding.
package gigatron_ps2_input_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    localparam logic [2:0] PAD_RIGHT  = 3'd0;
    localparam logic [2:0] PAD_LEFT   = 3'd1;
    localparam logic [2:0] PAD_DOWN   = 3'd2;
    localparam logic [2:0] PAD_UP     = 3'd3;
    localparam logic [2:0] PAD_START  = 3'd4;
    localparam logic [2:0] PAD_SELECT = 3'd5;
    localparam logic [2:0] PAD_B      = 3'd6;
    localparam logic [2:0] PAD_A      = 3'd7;

    localparam logic [7:0] INREG_IDLE = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } frame_state_e;

endpackage

// File: rtl/gigatron_ps2_keymap.sv
// Combinational scan-code set 2 lookup: maps a key code (with E0 prefix and
// shift state) to an ASCII byte and/or a gamepad bit position.
module gigatron_ps2_keymap
    import gigatron_ps2_input_pkg::*;
(
    input  logic       ext_i,
    input  logic [7:0] code_i,
    input  logic       shift_i,
    output logic       is_ascii_o,
    output logic [7:0] ascii_o,
    output logic       is_pad_o,
    output logic [2:0] pad_bit_o
);

    always_comb begin
        is_ascii_o = 1'b0;
        ascii_o    = 8'h00;
        is_pad_o   = 1'b0;
        pad_bit_o  = 3'd0;
        if (ext_i) begin
            case (code_i)
                8'h74:   begin is_pad_o = 1'b1; pad_bit_o = PAD_RIGHT; end
                8'h6B:   begin is_pad_o = 1'b1; pad_bit_o = PAD_LEFT;  end
                8'h72:   begin is_pad_o = 1'b1; pad_bit_o = PAD_DOWN;  end
                8'h75:   begin is_pad_o = 1'b1; pad_bit_o = PAD_UP;    end
                default: ;
            endcase
        end else begin
            is_ascii_o = 1'b1;
            case (code_i)
                8'h1C: ascii_o = 8'h61;  8'h32: ascii_o = 8'h62;
                8'h21: ascii_o = 8'h63;  8'h23: ascii_o = 8'h64;
                8'h24: ascii_o = 8'h65;  8'h2B: ascii_o = 8'h66;
                8'h34: ascii_o = 8'h67;  8'h33: ascii_o = 8'h68;
                8'h43: ascii_o = 8'h69;  8'h3B: ascii_o = 8'h6A;
                8'h42: ascii_o = 8'h6B;  8'h4B: ascii_o = 8'h6C;
                8'h3A: ascii_o = 8'h6D;  8'h31: ascii_o = 8'h6E;
                8'h44: ascii_o = 8'h6F;  8'h4D: ascii_o = 8'h70;
                8'h15: ascii_o = 8'h71;  8'h2D: ascii_o = 8'h72;
                8'h1B: ascii_o = 8'h73;  8'h2C: ascii_o = 8'h74;
                8'h3C: ascii_o = 8'h75;  8'h2A: ascii_o = 8'h76;
                8'h1D: ascii_o = 8'h77;  8'h22: ascii_o = 8'h78;
                8'h35: ascii_o = 8'h79;  8'h1A: ascii_o = 8'h7A;
                8'h45: ascii_o = 8'h30;  8'h16: ascii_o = 8'h31;
                8'h1E: ascii_o = 8'h32;  8'h26: ascii_o = 8'h33;
                8'h25: ascii_o = 8'h34;  8'h2E: ascii_o = 8'h35;
                8'h36: ascii_o = 8'h36;  8'h3D: ascii_o = 8'h37;
                8'h3E: ascii_o = 8'h38;  8'h46: ascii_o = 8'h39;
                8'h29: ascii_o = 8'h20;  8'h76: ascii_o = 8'h1B;
                8'h66: ascii_o = 8'h7F;  8'h5A: ascii_o = 8'h0A;
                default: is_ascii_o = 1'b0;
            endcase
            // Only letters change with shift; digits and controls are unshifted.
            if (shift_i && ascii_o >= 8'h61 && ascii_o <= 8'h7A) begin
                ascii_o = ascii_o - 8'h20;
            end
            case (code_i)
                8'h5A:   begin is_pad_o = 1'b1; pad_bit_o = PAD_START;  end
                8'h0D:   begin is_pad_o = 1'b1; pad_bit_o = PAD_SELECT; end
                8'h1A:   begin is_pad_o = 1'b1; pad_bit_o = PAD_B;      end
                8'h22:   begin is_pad_o = 1'b1; pad_bit_o = PAD_A;      end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/gigatron_ps2_input.sv
// PS/2 keyboard front end for the Gigatron input port: frame receiver, scan-code
// decoder, gamepad emulation and vsync-timed ASCII hold.
module gigatron_ps2_input
    import gigatron_ps2_input_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned HOLD_FRAMES    = 2
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    input  logic       vsync_i,
    output logic [7:0] inreg_o,
    output logic       key_valid_o,
    output logic       err_o
);

    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned HoldW  = $clog2(HOLD_FRAMES + 1);

    logic [1:0]        clk_sync_q, dat_sync_q;
    logic              clk_prev_q;
    frame_state_e      state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        data_q, data_d;
    logic              par_ok_q, par_ok_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              ext_q, ext_d, brk_q, brk_d, shift_q, shift_d;
    logic [7:0]        pad_q, pad_d, ascii_q, ascii_d, inreg_q, inreg_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic              vsync_q, key_valid_q, key_valid_d, err_q;

    logic       ps2_fall, ps2_bit, vs_fall, byte_ok, frame_err;
    logic       km_is_ascii, km_is_pad;
    logic [7:0] km_ascii;
    logic [2:0] km_pad_bit;

    assign ps2_bit  = dat_sync_q[1];
    assign ps2_fall = clk_prev_q & ~clk_sync_q[1];
    assign vs_fall  = vsync_q & ~vsync_i;

    gigatron_ps2_keymap u_keymap (
        .ext_i      (ext_q),
        .code_i     (data_q),
        .shift_i    (shift_q),
        .is_ascii_o (km_is_ascii),
        .ascii_o    (km_ascii),
        .is_pad_o   (km_is_pad),
        .pad_bit_o  (km_pad_bit)
    );

    // Frame receiver and inactivity timeout.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        par_ok_d  = par_ok_q;
        timer_d   = timer_q;
        byte_ok   = 1'b0;
        frame_err = 1'b0;
        if (state_q != StIdle) begin
            timer_d = ps2_fall ? '0 : timer_q + TimerW'(1);
        end
        if (ps2_fall) begin
            case (state_q)
                StIdle: begin
                    if (!ps2_bit) begin
                        state_d   = StData;
                        bit_cnt_d = 3'd0;
                        timer_d   = '0;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                StData: begin
                    data_d    = {ps2_bit, data_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
                StParity: begin
                    par_ok_d = ^{data_q, ps2_bit};
                    state_d  = StStop;
                end
                StStop: begin
                    if (ps2_bit && par_ok_q) byte_ok = 1'b1;
                    else                     frame_err = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle && timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
            state_d   = StIdle;
            frame_err = 1'b1;
        end
    end

    // Scan-code decoder, pad state and ASCII hold.
    always_comb begin
        ext_d       = ext_q;
        brk_d       = brk_q;
        shift_d     = shift_q;
        pad_d       = pad_q;
        ascii_d     = ascii_q;
        key_valid_d = 1'b0;
        hold_d      = (vs_fall && hold_q != '0) ? hold_q - HoldW'(1) : hold_q;
        if (byte_ok) begin
            if (data_q == SC_EXT) begin
                ext_d = 1'b1;
            end else if (data_q == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (!ext_q && (data_q == SC_LSHIFT || data_q == SC_RSHIFT)) begin
                    shift_d = ~brk_q;
                end
                if (km_is_pad) begin
                    pad_d[km_pad_bit] = brk_q;
                    if (!brk_q) key_valid_d = 1'b1;
                end
                if (km_is_ascii && !brk_q) begin
                    ascii_d     = km_ascii;
                    hold_d      = HoldW'(HOLD_FRAMES);
                    key_valid_d = 1'b1;
                end
            end
        end
        inreg_d = (hold_d != '0) ? ascii_d : pad_d;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            clk_prev_q  <= 1'b1;
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd0;
            data_q      <= 8'h00;
            par_ok_q    <= 1'b0;
            timer_q     <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            shift_q     <= 1'b0;
            pad_q       <= INREG_IDLE;
            ascii_q     <= 8'h00;
            hold_q      <= '0;
            vsync_q     <= 1'b1;
            inreg_q     <= INREG_IDLE;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q  <= {dat_sync_q[0], ps2_dat_i};
            clk_prev_q  <= clk_sync_q[1];
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            data_q      <= data_d;
            par_ok_q    <= par_ok_d;
            timer_q     <= timer_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            shift_q     <= shift_d;
            pad_q       <= pad_d;
            ascii_q     <= ascii_d;
            hold_q      <= hold_d;
            vsync_q     <= vsync_i;
            inreg_q     <= inreg_d;
            key_valid_q <= key_valid_d;
            err_q       <= frame_err;
        end
    end

    assign inreg_o     = inreg_q;
    assign key_valid_o = key_valid_q;
    assign err_o       = err_q;

endmodule
